// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into NIBBLES-wide words with valid/ready
// handshakes on both sides, a synchronous flush and a one-deep output register.
module nibble_packer #(
   parameter int unsigned NIBBLES   = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             nib_in,
   input  logic                   nib_valid,
   output logic                   nib_ready,
   input  logic                   flush,
   output logic [4*NIBBLES-1:0]   word_out,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic [2:0]             fill_cnt
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned SH_W = 6;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t            state;
   logic [W-1:0]      acc;
   logic [SH_W-1:0]   shift;
   logic [SH_W-1:0]   slot_base;
   logic [W-1:0]      placed;
   logic              last;
   logic              accept;
   logic              consume;
   logic              complete;

   // Bit position of the incoming nibble inside the accumulator.
   always_comb begin
      slot_base = {1'b0, fill_cnt, 2'b00};
      shift     = slot_base;
      if (MSB_FIRST) begin
         shift = SH_W'(W - 4) - slot_base;
      end
      placed = W'(nib_in) << shift;
   end

   // Handshake qualifiers; the final nibble stalls only if it would clobber an
   // unconsumed word, and flush blocks all intake.
   always_comb begin
      last      = (fill_cnt == 3'(NIBBLES - 1));
      nib_ready = !flush && (!last || !word_valid || word_ready);
      accept    = nib_valid && nib_ready;
      consume   = word_valid && word_ready;
      complete  = accept && last;
   end

   assign word_valid = (state == FULL);

   // Accumulator, fill counter, output word and FILL/FULL state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FILL;
         acc      <= '0;
         fill_cnt <= 3'd0;
         word_out <= '0;
      end else begin
         if (flush) begin
            acc      <= '0;
            fill_cnt <= 3'd0;
         end else if (accept) begin
            if (last) begin
               acc      <= '0;
               fill_cnt <= 3'd0;
            end else begin
               acc      <= acc | placed;
               fill_cnt <= fill_cnt + 3'd1;
            end
         end

         if (complete) begin
            word_out <= acc | placed;
         end

         case (state)
            FILL: if (complete) state <= FULL;
            FULL: if (consume && !complete) state <= FILL;
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL provide parameter NIBBLES, default 2: nibbles per output word; legal range 2..8; word width W = 4*NIBBLES.
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = first nibble lands in word[W-1 -: 4]; 0 = first nibble lands in word[0 +: 4].
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port nib_in  input  4  input nibble.
REQ-006 SHALL have port nib_valid  input  1  nib_in valid.
REQ-007 SHALL have port nib_ready  output  1  packer accepts nib_in this cycle.
REQ-008 SHALL have port flush  input  1  synchronous discard of the partial word.
REQ-009 SHALL have port word_out  output  W  assembled word.
REQ-010 SHALL have port word_valid  output  1  word_out valid.
REQ-011 SHALL have port word_ready  input  1  downstream accepts word_out.
REQ-012 SHALL have port fill_cnt  output  3  nibbles held in the partial word, 0..NIBBLES-1.

Function
REQ-013 A nibble SHALL be accepted only on a cycle where nib_valid=1 and nib_ready=1.
REQ-014 A word SHALL be consumed only on a cycle where word_valid=1 and word_ready=1.
REQ-015 The k-th accepted nibble (k=0..NIBBLES-1) SHALL be written to accumulator slice [W-1-4k -: 4] when MSB_FIRST=1, and to [4k +: 4] when MSB_FIRST=0.
REQ-016 Accepting a non-final nibble SHALL increment fill_cnt by 1.
REQ-017 Accepting the final nibble (fill_cnt=NIBBLES-1) SHALL:
- load the completed word into the word_out register;
- set word_valid=1 on the next cycle (latency one clock from last-nibble acceptance);
- wrap fill_cnt to 0.
REQ-018 nib_ready SHALL be combinational: 1 when fill_cnt != NIBBLES-1, or word_valid=0, or word_ready=1. It SHALL be 0 only when the final nibble would overwrite an unconsumed word.
REQ-019 Accumulation of non-final nibbles SHALL continue while word_valid=1 and word_ready=0; word_out SHALL remain stable until consumed.
REQ-020 On a cycle where the word is consumed and a final nibble is accepted together, the new word SHALL replace word_out and word_valid SHALL stay 1. Back-to-back words at one nibble per cycle SHALL sustain with no bubble.
REQ-021 When a word is consumed with no new completion, word_valid SHALL fall to 0 on the next cycle.
REQ-022 While flush=1:
- fill_cnt SHALL clear to 0 next cycle and the accumulator SHALL clear to 0;
- nib_ready SHALL be 0;
- word_out and word_valid SHALL be unaffected, and a pending word SHALL still be consumable.
REQ-023 Accumulator slices not yet written in the current word SHALL hold 0, so a word only ever contains nibbles of that word.
REQ-024 Internal state SHALL be two-state:
- FILL (word_valid=0) -> FULL on final-nibble acceptance;
- FULL -> FILL on consumption without a simultaneous completion;
- FULL -> FULL on consumption with a completion, or when not consumed.

Reset
REQ-025 While rst_n=0, state SHALL immediately be: word_out=0, word_valid=0, fill_cnt=0, accumulator=0, FILL state.
REQ-026 Reset asserted mid-word SHALL discard partial nibbles and any pending word; the first nibble after release SHALL be treated as k=0.
REQ-027 nib_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (NIBBLES=2 unless noted)
REQ-028 MSB_FIRST=1, word_ready=1, nibbles 4'hD then 4'h5 on consecutive cycles -> word_out=8'hD5 with word_valid=1 one cycle after 4'h5 is accepted.
REQ-029 MSB_FIRST=0, nibbles 4'h5, 4'hD, 4'h0, 4'hF streamed with word_ready=1 -> words 8'hD5 then 8'hF0 on back-to-back valid cycles; nib_ready never drops.
REQ-030 Backpressure: 8'hAA pending with word_ready=0, nibble 4'hF is accepted (fill_cnt=1), next nibble 4'h0 sees nib_ready=0 -> word_out holds 8'hAA. Raising word_ready -> 8'hAA consumed, 4'h0 accepted the same cycle, next word 8'hF0.
REQ-031 Flush after nibble 4'h3 (fill_cnt=1), then nibbles 4'hC, 4'h1 -> word 8'hC1; the 4'h3 never appears.
REQ-032 Assert rst_n=0 mid-clock with fill_cnt=1 and word_valid=1 -> outputs zero immediately, without waiting for a clock edge; after release, nibbles 4'hB, 4'h7 -> 8'hB7.
REQ-033 NIBBLES=4, MSB_FIRST=1, nibbles 1,2,3,4 -> word_out=16'h1234; fill_cnt steps 0,1,2,3,0.
